// File: rtl/nic_interface_if.sv
// Bundle of the processor access port and the router port of nic_interface.
// master drives accesses and router inputs; slave is the NIC itself.
interface nic_interface_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicEnWr;

  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;

  modport master (
    output addr, d_in, nicEn, nicEnWr, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

  modport slave (
    input  addr, d_in, nicEn, nicEnWr, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/nic_interface.sv
// nic_interface: bridges the pipeline to one router port through an inbound and an outbound buffer.
// Define NIC_OUT_DEPTH2_EN to make the outbound buffer a 2-entry FIFO.
module nic_interface #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  nic_interface_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_BUF   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_STAT  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_BUF  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_STAT = ADDR_WIDTH'(3);

  logic                  rd_en;
  logic                  wr_en;
  logic                  in_full;
  logic [DATA_WIDTH-1:0] in_buf;
  logic                  out_full;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_head;
  logic                  out_push;
  logic                  out_pop;

  assign rd_en = bus.nicEn & ~bus.nicEnWr;
  assign wr_en = bus.nicEn & bus.nicEnWr;

  // Inbound ready depends only on the registered flag, never on net_si.
  assign bus.net_ri = ~in_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_full <= 1'b0;
      in_buf  <= '0;
    end else if (bus.net_si && !in_full) begin
      in_buf  <= bus.net_di;
      in_full <= 1'b1;
    end else if (rd_en && (bus.addr == ADDR_IN_BUF)) begin
      in_full <= 1'b0;
    end
  end

  // The write gate sees pre-edge fullness, so a write racing a drain of a full buffer is lost.
  assign out_push   = wr_en && (bus.addr == ADDR_OUT_BUF) && !out_full;
  assign bus.net_so = out_valid && (out_head[DATA_WIDTH-1] == bus.net_polarity);
  assign out_pop    = bus.net_so && bus.net_ro;
  assign bus.net_do = out_head;

`ifdef NIC_OUT_DEPTH2_EN
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  head_ptr;
  logic                  tail_ptr;
  logic [1:0]            count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      head_ptr    <= 1'b0;
      tail_ptr    <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (out_push) begin
        fifo_mem[tail_ptr] <= bus.d_in;
        tail_ptr           <= ~tail_ptr;
      end
      if (out_pop) begin
        head_ptr <= ~head_ptr;
      end
      count <= count + {1'b0, out_push} - {1'b0, out_pop};
    end
  end

  assign out_full  = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_head  = fifo_mem[head_ptr];
`else
  logic [DATA_WIDTH-1:0] out_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_full <= 1'b0;
      out_buf  <= '0;
    end else if (out_push) begin
      out_buf  <= bus.d_in;
      out_full <= 1'b1;
    end else if (out_pop) begin
      out_full <= 1'b0;
    end
  end

  assign out_valid = out_full;
  assign out_head  = out_buf;
`endif

  // Zero-latency register read; the write-only outbound buffer reads as zero.
  always_comb begin
    bus.d_out = '0;
    if (rd_en) begin
      case (bus.addr)
        ADDR_IN_BUF:   bus.d_out = in_buf;
        ADDR_IN_STAT:  bus.d_out = DATA_WIDTH'(in_full);
        ADDR_OUT_STAT: bus.d_out = DATA_WIDTH'(out_full);
        default:       bus.d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_interface.sv
// Scoreboard bench for nic_interface: directed scenarios plus random traffic against a queue-based model.
// Build with NIC_OUT_DEPTH2_EN defined to check the 2-entry outbound FIFO.
module tb_nic_interface;

  localparam int DW = 64;
  localparam int AW = 2;
`ifdef NIC_OUT_DEPTH2_EN
  localparam int OUT_CAP = 2;
`else
  localparam int OUT_CAP = 1;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [DW-1:0] m_out[$];
  logic [DW-1:0] exp_flit[$];
  logic [DW-1:0] exp_read[$];
  logic          m_in_full;
  logic [DW-1:0] m_in_val;
  logic          exp_so;
  logic          pol_r;
  logic          ro_r;

  nic_interface_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  nic_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at posedge+1, record expectations, update the model after the edge.
  task automatic applyStimulus(input logic en, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] din, input logic si, input logic [DW-1:0] di,
                               input logic ro, input logic pol);
    logic fill;
    logic accept;
    logic xfer;
    bus.nicEn        = en;
    bus.nicEnWr      = wr;
    bus.addr         = a;
    bus.d_in         = din;
    bus.net_si       = si;
    bus.net_di       = di;
    bus.net_ro       = ro;
    bus.net_polarity = pol;
    if (en && !wr) begin
      case (a)
        2'd0:    exp_read.push_back(m_in_val);
        2'd1:    exp_read.push_back(DW'(m_in_full));
        2'd3:    exp_read.push_back(DW'(m_out.size() == OUT_CAP));
        default: exp_read.push_back('0);
      endcase
    end
    fill   = si && !m_in_full;
    xfer   = (m_out.size() > 0) && (m_out[0][DW-1] == pol) && ro;
    accept = en && wr && (a == 2'd2) && (m_out.size() < OUT_CAP);
    @(posedge clk);
    #1;
    if (fill) begin
      m_in_full = 1'b1;
      m_in_val  = di;
    end else if (en && !wr && (a == 2'd0)) begin
      m_in_full = 1'b0;
    end
    if (xfer) void'(m_out.pop_front());
    if (accept) begin
      m_out.push_back(din);
      exp_flit.push_back(din);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, ro_r, pol_r);
  endtask

  task automatic clearModel();
    m_out.delete();
    exp_flit.delete();
    exp_read.delete();
    m_in_full = 1'b0;
    m_in_val  = '0;
  endtask

  // Monitor: mid-cycle, compare every presented read and flit against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.nicEn && !bus.nicEnWr) begin
        if (exp_read.size() == 0) checkOutput("read_unexpected", bus.d_out, 'x);
        else checkOutput("d_out_read", bus.d_out, exp_read.pop_front());
      end else begin
        checkOutput("d_out_idle", bus.d_out, '0);
      end
      checkOutput("net_ri", DW'(bus.net_ri), DW'(!m_in_full));
      exp_so = (exp_flit.size() > 0) && (exp_flit[0][DW-1] == bus.net_polarity);
      checkOutput("net_so", DW'(bus.net_so), DW'(exp_so));
      if (bus.net_so && bus.net_ro) begin
        if (exp_flit.size() == 0) checkOutput("flit_unexpected", bus.net_do, 'x);
        else checkOutput("net_do", bus.net_do, exp_flit.pop_front());
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    pol_r = 1'b0;
    ro_r  = 1'b0;
    bus.nicEn = 1'b0; bus.nicEnWr = 1'b0; bus.addr = '0; bus.d_in = '0;
    bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    clearModel();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_net_ri", DW'(bus.net_ri), DW'(1));
    checkOutput("rst_net_so", DW'(bus.net_so), '0);
    checkOutput("rst_net_do", bus.net_do, '0);
    checkOutput("rst_d_out", bus.d_out, '0);
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] inbound fill and drain");
    applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] outbound polarity gating");
    ro_r = 1'b1; pol_r = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_00AA, 1'b0, '0, ro_r, pol_r);
    idle(5);
    pol_r = 1'b1;
    idle(2);
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, ro_r, pol_r);

    $display("[TB] overflow drop");
    ro_r = 1'b0; pol_r = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h1, 1'b0, '0, ro_r, pol_r);
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h2, 1'b0, '0, ro_r, pol_r);
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, ro_r, pol_r);
    checkOutput("ovf_net_do", bus.net_do, m_out[0]);
    ro_r = 1'b1;
    idle(4);

    $display("[TB] write racing drain");
    ro_r = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h5, 1'b0, '0, ro_r, pol_r);
    ro_r = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h3, 1'b0, '0, ro_r, pol_r);
    idle(3);
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, ro_r, pol_r);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      logic          en;
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] din;
      logic [DW-1:0] di;
      en  = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1) == 1;
      a   = AW'($urandom_range(0, 3));
      din = {$urandom, $urandom};
      di  = {$urandom, $urandom};
      ro_r = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) pol_r = ~pol_r;
      applyStimulus(en, wr, a, din, ($urandom_range(0, 3) == 0), di, ro_r, pol_r);
    end

    $display("[TB] asynchronous reset mid-operation");
    ro_r = 1'b0; pol_r = 1'b1;
    idle(1);
    applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, 64'h1234, ro_r, pol_r);
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_0077, 1'b0, '0, ro_r, pol_r);
    applyStimulus(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_0088, 1'b0, '0, ro_r, pol_r);
    bus.nicEn = 1'b0; bus.net_si = 1'b0;
    checkOutput("pre_rst_ri", DW'(bus.net_ri), DW'(!m_in_full));
    checkOutput("pre_rst_so", DW'(bus.net_so), DW'((m_out.size() > 0) && (m_out[0][DW-1] == pol_r)));
    #2 rst = 1'b0;
    #1;
    checkOutput("async_net_ri", DW'(bus.net_ri), DW'(1));
    checkOutput("async_net_so", DW'(bus.net_so), '0);
    checkOutput("async_net_do", bus.net_do, '0);
    clearModel();
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, ro_r, pol_r);
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, ro_r, pol_r);
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, '0, ro_r, pol_r);
    idle(2);
    checkOutput("read_queue_drained", DW'(exp_read.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
